decode_stage: RTL and testbench

Registered RV32I instruction-decode stage for the in-order pipeline, sitting between the fetch/ID register and the execute stage. It decodes one instruction per cycle into a `PipelineReg::EX_STATE` control word and holds it in an output register behind a valid/ready handshake. An internal rd scoreboard, `HAZ_DEPTH` entries deep, detects RAW hazards and inserts bubbles in one of two modes: load-use-only for forwarding builds, or full interlock. A saturating stall counter is included for performance analysis.

---
 rtl/ISA.sv | 19 +
 rtl/PipelineReg.sv | 53 +++++
 rtl/rv32i_ctrl_decode.sv | 91 +++++++++
 rtl/decode_stage.sv | 127 ++++++++++++
 tb/tb_decode_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ISA.sv
// ---------------------------------------------------------------------------
// ISA: RV32I base opcode constants used by the decode stage.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ISA;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

`default_nettype wire

// File: rtl/PipelineReg.sv
// ---------------------------------------------------------------------------
// PipelineReg: pipeline register types shared between fetch, decode, execute.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package PipelineReg;
    typedef enum logic [2:0] {
        ALU_LDST   = 3'b000,
        ALU_BRANCH = 3'b001,
        ALU_R      = 3'b010,
        ALU_I      = 3'b011,
        ALU_LUI    = 3'b100,
        ALU_AUIPC  = 3'b101,
        ALU_JAL    = 3'b110,
        ALU_JALR   = 3'b111
    } ALU_OP;

    typedef enum logic [1:0] {
        SRC_RS2 = 2'b00,
        SRC_IMM = 2'b01,
        SRC_PC  = 2'b10
    } ALU_SRC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ID_STATE;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        ALU_OP       alu_op;
        ALU_SRC      alu_src;
        logic [2:0]  func3;
        logic        func7;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } EX_STATE;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } SB_ENTRY;
endpackage

`default_nettype wire

// File: rtl/rv32i_ctrl_decode.sv
// ---------------------------------------------------------------------------
// rv32i_ctrl_decode: combinational RV32I instruction -> control word mapping.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv32i_ctrl_decode
    import PipelineReg::*;
    import ISA::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output EX_STATE     ctrl,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        illegal
);
    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        writes_rd;

    assign opcode = instr[6:0];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl       = '0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        illegal    = 1'b0;
        writes_rd  = 1'b0;
        ctrl.pc    = pc;
        ctrl.func3 = instr[14:12];
        ctrl.func7 = instr[30];
        case (opcode)
            OPC_OP: begin
                ctrl.alu_op = ALU_R;    ctrl.alu_src = SRC_RS2;
                rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.alu_op = ALU_I;    ctrl.alu_src = SRC_IMM; ctrl.imm = imm_i;
                rs1_used = 1'b1; writes_rd = 1'b1;
            end
            OPC_LUI: begin
                ctrl.alu_op = ALU_LUI;  ctrl.alu_src = SRC_IMM; ctrl.imm = imm_u;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alu_op = ALU_AUIPC; ctrl.alu_src = SRC_PC; ctrl.imm = imm_u;
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.alu_op = ALU_LDST; ctrl.alu_src = SRC_IMM; ctrl.imm = imm_i;
                ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
                rs1_used = 1'b1; writes_rd = 1'b1;
            end
            OPC_STORE: begin
                ctrl.alu_op = ALU_LDST; ctrl.alu_src = SRC_IMM; ctrl.imm = imm_s;
                ctrl.mem_write = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.alu_op = ALU_BRANCH; ctrl.alu_src = SRC_RS2; ctrl.imm = imm_b;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_JAL: begin
                ctrl.alu_op = ALU_JAL;  ctrl.alu_src = SRC_PC;  ctrl.imm = imm_j;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                ctrl.alu_op = ALU_JALR; ctrl.alu_src = SRC_IMM; ctrl.imm = imm_i;
                rs1_used = 1'b1; writes_rd = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // Fields without a register meaning are zeroed so the hazard check never sees them.
        ctrl.rs1       = rs1_used  ? instr[19:15] : 5'd0;
        ctrl.rs2       = rs2_used  ? instr[24:20] : 5'd0;
        ctrl.rd        = writes_rd ? instr[11:7]  : 5'd0;
        ctrl.reg_write = writes_rd && (instr[11:7] != 5'd0);
    end
endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage: registered RV32I decode with rd scoreboard and hazard bubbles.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_stage
    import PipelineReg::*;
#(
    parameter int HAZ_DEPTH = 3,
    parameter bit FWD_EN    = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  ID_STATE          id_state,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output EX_STATE          ex_state,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    EX_STATE                   dec_ctrl;
    logic                      dec_rs1_used;
    logic                      dec_rs2_used;
    logic                      dec_illegal;
    logic                      hazard;
    logic                      out_free;
    logic                      accept;
    logic                      bubble;

    logic                      out_valid_q,   out_valid_d;
    EX_STATE                   ex_state_q,    ex_state_d;
    logic                      illegal_q,     illegal_d;
    logic [CNT_W-1:0]          stall_count_q, stall_count_d;
    SB_ENTRY [HAZ_DEPTH-1:0]   slot_q,        slot_d;

    rv32i_ctrl_decode u_ctrl (
        .pc       (id_state.pc),
        .instr    (id_state.instr),
        .ctrl     (dec_ctrl),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used),
        .illegal  (dec_illegal)
    );

    // With forwarding only a load sitting in the output register can stall.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < HAZ_DEPTH; k++) begin
            if (slot_q[k].valid && (slot_q[k].rd != 5'd0) &&
                (!FWD_EN || ((k == 0) && slot_q[k].is_load))) begin
                if ((dec_rs1_used && (dec_ctrl.rs1 == slot_q[k].rd)) ||
                    (dec_rs2_used && (dec_ctrl.rs2 == slot_q[k].rd))) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard = hazard && in_valid;
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = reset && (flush || (!hazard && out_free));
    assign accept   = in_valid && in_ready && !flush;
    assign bubble   = hazard && out_free && !flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        ex_state_d    = ex_state_q;
        illegal_d     = illegal_q;
        stall_count_d = stall_count_q;
        slot_d        = slot_q;
        if (flush) begin
            out_valid_d = 1'b0;
            ex_state_d  = '0;
            illegal_d   = 1'b0;
            slot_d[0]   = '0;
        end else if (out_free) begin
            for (int k = HAZ_DEPTH - 1; k > 0; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            if (accept) begin
                out_valid_d = 1'b1;
                ex_state_d  = dec_ctrl;
                illegal_d   = dec_illegal;
                slot_d[0]   = SB_ENTRY'{valid: dec_ctrl.reg_write, rd: dec_ctrl.rd,
                                        is_load: dec_ctrl.mem_read};
            end else begin
                out_valid_d = 1'b0;
                ex_state_d  = '0;
                illegal_d   = 1'b0;
                slot_d[0]   = '0;
            end
            if (bubble && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            ex_state_q    <= '0;
            illegal_q     <= 1'b0;
            stall_count_q <= '0;
            slot_q        <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            ex_state_q    <= ex_state_d;
            illegal_q     <= illegal_d;
            stall_count_q <= stall_count_d;
            slot_q        <= slot_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign ex_state    = ex_state_q;
    assign illegal     = illegal_q;
    assign stall_count = stall_count_q;
endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage: scoreboard bench for decode_stage (forwarding and interlock builds).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;
    import PipelineReg::*;

    typedef struct packed {
        logic    ill;
        EX_STATE ex;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    ID_STATE     id_state = '0;
    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    EX_STATE     ex_state_a, ex_state_b;
    logic        illegal_a, illegal_b;
    logic [15:0] stall_count_a, stall_count_b;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc_ctr = 32'h100;
    exp_t        exp_a[$];
    exp_t        exp_b[$];

    always #5 clk = ~clk;

    decode_stage #(.HAZ_DEPTH(3), .FWD_EN(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .id_state(id_state), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
        .ex_state(ex_state_a), .illegal(illegal_a), .stall_count(stall_count_a)
    );

    decode_stage #(.HAZ_DEPTH(3), .FWD_EN(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .id_state(id_state), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
        .ex_state(ex_state_b), .illegal(illegal_b), .stall_count(stall_count_b)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [2:0] op, input logic [1:0] src,
                                input logic [2:0] f3, input logic f7, input logic rw,
                                input logic mr, input logic mw, input logic ill);
        exp_t e;
        e                 = '0;
        e.ill             = ill;
        e.ex.pc           = pc_ctr;
        e.ex.rs1          = rs1;
        e.ex.rs2          = rs2;
        e.ex.rd           = rd;
        e.ex.imm          = imm;
        e.ex.alu_op       = ALU_OP'(op);
        e.ex.alu_src      = ALU_SRC'(src);
        e.ex.func3        = f3;
        e.ex.func7        = f7;
        e.ex.reg_write    = rw;
        e.ex.mem_read     = mr;
        e.ex.mem_write    = mw;
        e.ex.mem_to_reg   = mr;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] instr, input bit push,
                        input exp_t e, output int waits);
        int n;
        id_state = '{pc: pc_ctr, instr: instr};
        pc_ctr   = pc_ctr + 32'd4;
        if (sel) in_valid_b = 1'b1;
        else     in_valid_a = 1'b1;
        n     = 0;
        waits = 0;
        forever begin
            @(negedge clk);
            if ((sel ? in_ready_b : in_ready_a) === 1'b1) break;
            waits++;
            n++;
            if (n >= 40) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=no_accept required=accept_within_40_cycles");
                break;
            end
        end
        if (n < 40 && push) begin
            if (sel) exp_b.push_back(e);
            else     exp_a.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && !flush && out_valid_a && out_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_output actual=out_valid required=none");
            end else begin
                e = exp_a.pop_front();
                chk("a_ex_state", 128'(ex_state_a), 128'(e.ex));
                chk("a_illegal", 128'(illegal_a), 128'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && !flush && out_valid_b && out_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_output actual=out_valid required=none");
            end else begin
                e = exp_b.pop_front();
                chk("b_ex_state", 128'(ex_state_b), 128'(e.ex));
                chk("b_illegal", 128'(illegal_b), 128'(e.ill));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   w;
        exp_t e_lui;

        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid_a", 128'(out_valid_a), 128'(0));
        chk("rst_in_ready_a", 128'(in_ready_a), 128'(0));
        chk("rst_ex_state_a", 128'(ex_state_a), 128'(0));
        chk("rst_stall_a", 128'(stall_count_a), 128'(0));
        chk("rst_out_valid_b", 128'(out_valid_b), 128'(0));
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic decode and one-cycle latency.
        send(0, 32'h00500093, 1'b1, mk(0, 0, 1, 32'd5, 3'b011, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        chk("addi_waits", 128'(w), 128'(0));
        @(negedge clk);
        chk("addi_latency_out_valid", 128'(out_valid_a), 128'(1));
        @(posedge clk);
        #1;

        // Load-use with forwarding: exactly one bubble.
        send(0, 32'h0000A103, 1'b1, mk(1, 0, 2, 32'd0, 3'b000, 2'b01, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), w);
        send(0, 32'h002101B3, 1'b1, mk(2, 2, 3, 32'd0, 3'b010, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        chk("loaduse_waits", 128'(w), 128'(1));
        chk("loaduse_stall_count", 128'(stall_count_a), 128'(1));

        // Remaining formats back to back.
        send(0, 32'h0020A423, 1'b1, mk(1, 2, 0, 32'd8, 3'b000, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), w);
        send(0, 32'hFE208EE3, 1'b1, mk(1, 2, 0, 32'hFFFFFFFC, 3'b001, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), w);
        send(0, 32'h008000EF, 1'b1, mk(0, 0, 1, 32'd8, 3'b110, 2'b10, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        send(0, 32'h00008067, 1'b1, mk(1, 0, 0, 32'd0, 3'b111, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), w);
        send(0, 32'h0000007F, 1'b1, mk(0, 0, 0, 32'd0, 3'b000, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), w);
        chk("stream_waits", 128'(w), 128'(0));
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: output held for four cycles, queued instruction follows.
        out_ready = 1'b0;
        e_lui = mk(0, 0, 5, 32'h12345000, 3'b100, 2'b01, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(0, 32'h123452B7, 1'b1, e_lui, w);
        id_state   = '{pc: pc_ctr, instr: 32'h00001217};
        in_valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid_a), 128'(1));
            chk("bp_in_ready", 128'(in_ready_a), 128'(0));
            chk("bp_ex_state", 128'(ex_state_a), 128'(e_lui.ex));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(0, 32'h00001217, 1'b1, mk(0, 0, 4, 32'h00001000, 3'b101, 2'b10, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        chk("bp_release_waits", 128'(w), 128'(0));
        @(negedge clk);
        chk("bp_release_out_valid", 128'(out_valid_a), 128'(1));
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Flush during a load-use stall.
        send(0, 32'h0000A103, 1'b0, mk(1, 0, 2, 32'd0, 3'b000, 2'b01, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), w);
        id_state   = '{pc: pc_ctr, instr: 32'h002101B3};
        pc_ctr     = pc_ctr + 32'd4;
        in_valid_a = 1'b1;
        flush      = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 128'(in_ready_a), 128'(1));
        @(posedge clk);
        #1;
        flush      = 1'b0;
        in_valid_a = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 128'(out_valid_a), 128'(0));
        chk("flush_stall_count", 128'(stall_count_a), 128'(1));
        @(posedge clk);
        #1;
        send(0, 32'h002101B3, 1'b1, mk(2, 2, 3, 32'd0, 3'b010, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        chk("post_flush_waits", 128'(w), 128'(0));
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(0, 32'h0000007F, 1'b0, mk(0, 0, 0, 32'd0, 3'b000, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), w);
        id_state   = '{pc: pc_ctr, instr: 32'h002101B3};
        in_valid_a = 1'b1;
        @(negedge clk);
        chk("pre_rst_illegal", 128'(illegal_a), 128'(1));
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid_a), 128'(0));
        chk("arst_ex_state", 128'(ex_state_a), 128'(0));
        chk("arst_illegal", 128'(illegal_a), 128'(0));
        chk("arst_stall_count", 128'(stall_count_a), 128'(0));
        chk("arst_in_ready", 128'(in_ready_a), 128'(0));
        in_valid_a = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        send(0, 32'h00500093, 1'b1, mk(0, 0, 1, 32'd5, 3'b011, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        chk("post_rst_waits", 128'(w), 128'(0));

        // Full interlock build: producer right ahead costs three bubbles.
        send(1, 32'h00500093, 1'b1, mk(0, 0, 1, 32'd5, 3'b011, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        send(1, 32'h001081B3, 1'b1, mk(1, 1, 3, 32'd0, 3'b010, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        chk("interlock_waits", 128'(w), 128'(3));
        chk("interlock_stall_count", 128'(stall_count_b), 128'(3));

        // x0 destination never creates a hazard.
        send(1, 32'h00100013, 1'b1, mk(0, 0, 0, 32'd1, 3'b011, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), w);
        send(1, 32'h000001B3, 1'b1, mk(0, 0, 3, 32'd0, 3'b010, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        chk("x0_waits", 128'(w), 128'(0));
        chk("x0_stall_count", 128'(stall_count_b), 128'(3));

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_drained", 128'(exp_a.size()), 128'(0));
        chk("b_queue_drained", 128'(exp_b.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
